// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and pointer/count width helpers for sync_fifo.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Pointer width for a given depth; a depth of 1 still needs one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointer and occupancy types for the default configuration.
    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] ptr_t;
    typedef logic [$clog2(DEFAULT_DEPTH):0]   count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH storage with one write port and one
// registered read port. The array itself is never reset; only the read
// register is cleared so the FIFO output starts at a known zero.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read-data value: load on a read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read-data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with one operation-select input.
// Define SYNC_FIFO_ASSERT_EN to compile in the protocol/consistency assertions.
//
// Request semantics: each cycle en=1 is a write request and en=0 is a read
// request. A write while full and a read while empty are silently ignored;
// the full/empty flags tell the surrounding logic in advance when that
// will happen. There is no back-pressure handshake beyond those flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             do_write;
    logic             do_read;

    // Flags come straight from the occupancy count.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Accepted operations and next pointer/count values. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        do_write = en && !full;
        do_read  = !en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end else if (do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset wins over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write && !rst),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (do_read),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

`ifdef SYNC_FIFO_ASSERT_EN
    a_flags_exclusive: assert property (@(posedge clk) disable iff (rst) !(full && empty))
        else $error("sync_fifo: full and empty both high");
    a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH))
        else $error("sync_fifo: count exceeds depth");
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(en && full))
        else $error("sync_fifo: write while full dropped");
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(!en && empty))
        else $error("sync_fifo: read while empty ignored");
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with a queue-based reference
// model checked every cycle and literal expectations for the test plan.
module tb_sync_fifo;

  localparam int DW  = 8;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout = '0;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_dout = '0;
      model_valid = 1'b1;
    end else if (en) begin
      if (exp_q.size() < DEP) exp_q.push_back(data_in);
    end else begin
      if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (data_out !== exp_dout) begin
        bad++;
        $display("FAIL model_dout t=%0t got=%h want=%h", $time, data_out, exp_dout);
      end
      total++;
      if (full !== (exp_q.size() == DEP)) begin
        bad++;
        $display("FAIL model_full t=%0t got=%b want=%b", $time, full, exp_q.size() == DEP);
      end
      total++;
      if (empty !== (exp_q.size() == 0)) begin
        bad++;
        $display("FAIL model_empty t=%0t got=%b want=%b", $time, empty, exp_q.size() == 0);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic cycle(input logic r, input logic e, input logic [DW-1:0] d);
    rst = r;
    en = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  logic [DW-1:0] wrap_exp[8];

  initial begin
    wrap_exp = '{8'h14, 8'h15, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};

    // Reset
    cycle(1'b1, 1'b0, 8'h00);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_dout", 32'(data_out), 32'h00);

    // Read on empty straight after reset
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 8'hA5);
      check("empty_read_dout", 32'(data_out), 32'h00);
      check("empty_read_flag", 32'(empty), 32'd1);
    end

    // Fill with 0x01..0x0A; last two are dropped
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 8'(i));
      check("fill_full", 32'(full), (i >= 8) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(empty), 32'd0);
    end
    check("fill_count", 32'(dut.count_q), 32'd8);
    check("fill_dout_unchanged", 32'(data_out), 32'h00);

    // Drain ten times
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check("drain_dout", 32'(data_out), (i <= 8) ? 32'(i) : 32'h08);
      check("drain_empty", 32'(empty), (i >= 8) ? 32'd1 : 32'd0);
    end

    // Wrap-around: write 5, read 3, write 6
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h11 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check("wrap_early_read", 32'(data_out), 32'h11 + 32'(i));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h21 + 8'(i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check("wrap_read", 32'(data_out), 32'(wrap_exp[i]));
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Mid-operation reset
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h31 + 8'(i));
    check("mid_not_empty", 32'(empty), 32'd0);
    cycle(1'b1, 1'b1, 8'h77);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dout", 32'(data_out), 32'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("mid_read_nothing", 32'(data_out), 32'h00);
    check("mid_read_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 8'h55);
    check("mid_write_not_empty", 32'(empty), 32'd0);
    cycle(1'b0, 1'b0, 8'h00);
    check("mid_fresh_read", 32'(data_out), 32'h55);
    check("mid_final_empty", 32'(empty), 32'd1);

    cycle(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
